// File: rtl/fcmp_flag_queue.sv
// FP compare flag queue: a circular FIFO of compare flags and jump types. The branch condition is evaluated as an entry loads into a registered output stage.
// Optional feature: define FCMPQ_STICKY_EN for the sticky invalid-exception flag.
module fcmp_flag_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_flags,
    input  logic [4:0]    in_jtype,
    input  logic          in_invexc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_taken,
    output logic          out_unord,
    output logic [AW:0]   count,
    output logic          sticky_inv,
    input  logic          clr_sticky
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [5:0]    flags_mem [DEPTH];
    logic [4:0]    jtype_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          load;
    logic          empty;
    logic [5:0]    rd_flags;
    logic [4:0]    rd_jtype;
    logic          c_flag;
    logic          z_flag;
    logic          s_flag;
    logic          u_flag;
    logic          cond;
    logic          unused_bits;

    assign in_ready = (count != FULL_CNT);
    assign empty    = (count == '0);
    assign push     = in_valid & in_ready & ~flush;
    assign load     = (~out_valid | out_ready) & ~empty & ~flush;
    assign rd_flags = flags_mem[rd_ptr];
    assign rd_jtype = jtype_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            flags_mem[wr_ptr] <= in_flags;
            jtype_mem[wr_ptr] <= in_jtype;
        end
    end

    // The condition is evaluated on the stored entry at the moment it moves into the output stage.
    always_comb begin
        c_flag = ~rd_flags[5];
        z_flag = rd_flags[1];
        s_flag = rd_flags[2];
        u_flag = rd_flags[4];
        cond   = 1'b0;
        case (rd_jtype[3:0])
            4'd0:    cond = 1'b1;
            4'd1:    cond = z_flag;
            4'd2:    cond = c_flag;
            4'd3:    cond = c_flag | z_flag;
            4'd4:    cond = s_flag;
            4'd5:    cond = s_flag | z_flag;
            4'd6:    cond = u_flag;
            4'd7:    cond = z_flag & ~u_flag;
            4'd8:    cond = c_flag & ~u_flag;
            4'd9:    cond = ~c_flag & ~z_flag & ~u_flag;
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_taken <= 1'b0;
            out_unord <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, load})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (load) begin
                out_valid <= 1'b1;
                out_taken <= cond ^ rd_jtype[4];
                out_unord <= rd_flags[4];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FCMPQ_STICKY_EN
    logic invexc_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            invexc_mem[wr_ptr] <= in_invexc;
        end
    end

    // A set event in the same cycle as clr_sticky wins; flush leaves the flag alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_inv <= 1'b0;
        end else if (load && rd_flags[4] && invexc_mem[rd_ptr]) begin
            sticky_inv <= 1'b1;
        end else if (clr_sticky) begin
            sticky_inv <= 1'b0;
        end
    end

    assign unused_bits = rd_flags[3] ^ rd_flags[0];
`else
    assign sticky_inv  = 1'b0;
    assign unused_bits = rd_flags[3] ^ rd_flags[0] ^ clr_sticky ^ in_invexc;
`endif

endmodule
